// File: rtl/msrv32_dmem_responder.sv
// msrv32_dmem_responder: AHB-lite style data RAM responder with wait states; MSRV32_DMEM_STATS_EN adds wr_count_out
module msrv32_dmem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] dmaddr_in,
    input  logic [31:0] dmdata_in,
    input  logic [3:0]  dmwr_mask_in,
    input  logic        dmwr_req_in,
    input  logic        dmrd_req_in,
    input  logic [1:0]  htrans_in,
    output logic        ahb_ready_out,
    output logic [31:0] dmdata_out,
    output logic        resp_err_out
`ifdef MSRV32_DMEM_STATS_EN
    ,
    output logic [31:0] wr_count_out
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, data_q;
    logic [3:0]  mask_q;
    logic        is_wr;
    logic [31:0] mem [0:2**ADDR_WIDTH-1];
    logic        accept, in_range, commit;
    logic [32:0] diff;
    logic [ADDR_WIDTH-1:0] idx;
    logic        unused_lsb;
    assign accept     = htrans_in == 2'b10 && (dmwr_req_in || dmrd_req_in) && state != WAIT;
    assign diff       = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign in_range   = !diff[32] && diff[31:ADDR_WIDTH+2] == '0;
    assign idx        = diff[ADDR_WIDTH+1:2];
    assign unused_lsb = ^diff[1:0];
    assign commit     = state == DATA && is_wr && in_range;
    assign dmdata_out = (state == DATA && !is_wr && in_range) ? mem[idx] : 32'h0;
    assign resp_err_out = state == DATA && !in_range;
    // Transfer FSM: address-phase capture, wait-state countdown, registered ready
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            ahb_ready_out <= 1'b1;
            addr_q        <= 32'h0;
            data_q        <= 32'h0;
            mask_q        <= 4'h0;
            is_wr         <= 1'b0;
        end else if (state == WAIT) begin
            if (cnt == 4'd0) begin
                state         <= DATA;
                ahb_ready_out <= 1'b1;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (accept) begin
            addr_q <= dmaddr_in;
            data_q <= dmdata_in;
            mask_q <= dmwr_mask_in;
            is_wr  <= dmwr_req_in;
            if (WAIT_STATES == 0) begin
                state         <= DATA;
                ahb_ready_out <= 1'b1;
            end else begin
                state         <= WAIT;
                cnt           <= 4'(WAIT_STATES - 1);
                ahb_ready_out <= 1'b0;
            end
        end else begin
            state         <= IDLE;
            ahb_ready_out <= 1'b1;
        end
    end
    // Byte-masked write committed on the edge that leaves DATA
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (commit)
            for (int i = 0; i < 4; i++)
                if (mask_q[i]) mem[idx][8*i+:8] <= data_q[8*i+:8];
    end
`ifdef MSRV32_DMEM_STATS_EN
    // Saturating count of committed in-range writes
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) wr_count_out <= 32'h0;
        else if (commit && wr_count_out != 32'hFFFF_FFFF) wr_count_out <= wr_count_out + 32'd1;
    end
`endif
endmodule
